// File: rtl/bp_stat_pkg.sv
// Shared types and constants for the branch-predictor measurement controller.
// Holds the FSM encoding, read-select codes, status bit positions and halt marker.
package bp_stat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] SEL_CYC    = 2'd0;
    localparam logic [1:0] SEL_BR     = 2'd1;
    localparam logic [1:0] SEL_MISS   = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    localparam int STAT_CYC_OVF  = 2;
    localparam int STAT_BR_OVF   = 3;
    localparam int STAT_MISS_OVF = 4;

    localparam logic [31:0] HALT_INSN_DEF = 32'h0000_006F;

endpackage

// File: rtl/bp_sat_cnt.sv
// Saturating up-counter with sticky overflow.
// A clear restarts the count; an event coincident with the clear counts as the first.
module bp_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         ovf_o
);

    logic [W-1:0] cnt_q;
    logic         ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q <= {{(W-1){1'b0}}, en_i};
            ovf_q <= 1'b0;
        end else if (en_i) begin
            if (&cnt_q) ovf_q <= 1'b1;
            else        cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/bp_stat_ctrl.sv
// Branch-predictor measurement run controller with registered statistics read port.
// Optional per-window miss reporting is compiled in with BP_STAT_WINDOW_EN.
module bp_stat_ctrl
    import bp_stat_pkg::*;
#(
    parameter logic [31:0] HALT_INSN    = HALT_INSN_DEF,
    parameter int          HALT_HOLD    = 4,
    parameter int          DRAIN_CYCLES = 3,
    parameter int          WINDOW       = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        clear_i,
    input  logic        br_instr_i,
    input  logic        br_miss_i,
    input  logic [31:0] instr_i,
    input  logic [1:0]  rd_sel_i,
    output logic [31:0] rd_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        win_valid_o,
    output logic [15:0] win_miss_o
);

    if (HALT_HOLD < 2 || HALT_HOLD > 15) begin : g_bad_hold
        $error("HALT_HOLD must be 2..15");
    end
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
        $error("DRAIN_CYCLES must be 1..15");
    end
    if (WINDOW < 2 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_win
        $error("WINDOW must be a power of two");
    end

    state_e      state_q, state_d;
    logic [3:0]  match_q, match_d;
    logic [3:0]  drain_q, drain_d;
    logic        busy, start_run, cnt_clr;
    logic        insn_hit, halt_hit;
    logic [31:0] cyc_cnt, br_cnt, miss_cnt;
    logic        cyc_ovf, br_ovf, miss_ovf;
    logic [31:0] status, rd_d, rd_q;

    assign busy      = (state_q == ST_RUN) | (state_q == ST_DRAIN);
    assign start_run = start_i & ~clear_i &
                       ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign cnt_clr   = clear_i | start_run;
    assign insn_hit  = (instr_i == HALT_INSN);
    assign halt_hit  = (state_q == ST_RUN) & insn_hit &
                       (match_q == 4'(HALT_HOLD - 1));

    always_comb begin
        state_d = state_q;
        match_d = 4'd0;
        drain_d = drain_q;
        unique case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN: begin
                if (insn_hit) match_d = match_q + 4'd1;
                if (halt_hit) begin
                    state_d = ST_DRAIN;
                    drain_d = 4'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q - 4'd1;
                if (drain_q == 4'd1) state_d = ST_DONE;
            end
            ST_DONE: if (start_i) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
        if (clear_i) begin
            state_d = ST_IDLE;
            match_d = 4'd0;
            drain_d = 4'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            match_q <= 4'd0;
            drain_q <= 4'd0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            drain_q <= drain_d;
        end
    end

    bp_sat_cnt #(.W(32)) u_cyc_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .en_i   (busy & ~clear_i),
        .cnt_o  (cyc_cnt),
        .ovf_o  (cyc_ovf)
    );

    bp_sat_cnt #(.W(32)) u_br_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .en_i   (busy & ~clear_i & br_instr_i),
        .cnt_o  (br_cnt),
        .ovf_o  (br_ovf)
    );

    bp_sat_cnt #(.W(32)) u_miss_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .en_i   (busy & ~clear_i & br_instr_i & br_miss_i),
        .cnt_o  (miss_cnt),
        .ovf_o  (miss_ovf)
    );

    always_comb begin
        status                = '0;
        status[1:0]           = state_q;
        status[STAT_CYC_OVF]  = cyc_ovf;
        status[STAT_BR_OVF]   = br_ovf;
        status[STAT_MISS_OVF] = miss_ovf;
    end

    always_comb begin
        rd_d = '0;
        unique case (rd_sel_i)
            SEL_CYC:    rd_d = cyc_cnt;
            SEL_BR:     rd_d = br_cnt;
            SEL_MISS:   rd_d = miss_cnt;
            SEL_STATUS: rd_d = status;
            default:    rd_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rd_q <= '0;
        else         rd_q <= rd_d;
    end

    assign rd_data_o = rd_q;
    assign busy_o    = busy;
    assign done_o    = (state_q == ST_DONE);

`ifdef BP_STAT_WINDOW_EN
    localparam int WW = $clog2(WINDOW);

    logic [WW-1:0] win_q;
    logic          win_end, win_ev, win_ovf;
    logic [15:0]   win_cnt, win_last, win_miss_q;
    logic          win_valid_q;

    assign win_end = busy & (win_q == WW'(WINDOW - 1));
    assign win_ev  = busy & ~clear_i & br_instr_i & br_miss_i;

    // The closing cycle's miss is folded into the reported value.
    assign win_last = (win_ovf | (&win_cnt)) ? 16'hFFFF :
                      win_cnt + {15'd0, win_ev};

    bp_sat_cnt #(.W(16)) u_win_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr | win_end),
        .en_i   (win_ev & ~win_end),
        .cnt_o  (win_cnt),
        .ovf_o  (win_ovf)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_q       <= '0;
            win_valid_q <= 1'b0;
            win_miss_q  <= '0;
        end else begin
            win_valid_q <= 1'b0;
            if (cnt_clr) begin
                win_q      <= '0;
                win_miss_q <= '0;
            end else if (busy) begin
                win_q <= win_q + 1'b1;
                if (win_end) begin
                    win_valid_q <= 1'b1;
                    win_miss_q  <= win_last;
                end
            end
        end
    end

    assign win_valid_o = win_valid_q;
    assign win_miss_o  = win_miss_q;
`else
    assign win_valid_o = 1'b0;
    assign win_miss_o  = 16'd0;
`endif

endmodule

// File: tb/tb_bp_stat_ctrl.sv
// Self-checking bench for bp_stat_ctrl; read results checked through an expected-value queue.
// Window checks are included when BP_STAT_WINDOW_EN is defined.
module tb_bp_stat_ctrl;
    import bp_stat_pkg::*;

    localparam logic [31:0] HALT = 32'h0000_006F;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        br_instr_i = 1'b0;
    logic        br_miss_i = 1'b0;
    logic [31:0] instr_i = NOP;
    logic [1:0]  rd_sel_i = 2'd0;
    logic [31:0] rd_data_o;
    logic        busy_o, done_o, win_valid_o;
    logic [15:0] win_miss_o;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    bp_stat_ctrl #(
        .HALT_INSN    (HALT),
        .HALT_HOLD    (4),
        .DRAIN_CYCLES (3),
        .WINDOW       (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .clear_i     (clear_i),
        .br_instr_i  (br_instr_i),
        .br_miss_i   (br_miss_i),
        .instr_i     (instr_i),
        .rd_sel_i    (rd_sel_i),
        .rd_data_o   (rd_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .win_valid_o (win_valid_o),
        .win_miss_o  (win_miss_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_issue(input logic [1:0] sel, input logic [31:0] e);
        rd_sel_i = sel;
        exp_q.push_back(e);
        step();
    endtask

    task automatic start_run();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic run_halt(output int n);
        instr_i    = HALT;
        br_instr_i = 1'b0;
        br_miss_i  = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!done_o && n < 40);
        instr_i = NOP;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        n_vec++;
        if (rd_data_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_rd: got %h expected 0", rd_data_o);
        end
        n_vec++;
        if ({busy_o, done_o, win_valid_o, win_miss_o} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 0",
                     {busy_o, done_o, win_valid_o, win_miss_o});
        end
        for (int i = 0; i < 4; i++) begin
            rd_issue(2'(i), 32'd0);
            e = exp_q.pop_front();
            n_vec++;
            if (rd_data_o !== e) begin
                n_err++;
                $display("FAIL reset_sel%0d: got %h expected %h", i, rd_data_o, e);
            end
        end
    endtask

    task automatic test_run();
        int n;
        logic [31:0] e;
        logic [31:0] exp_v[4];
        int nb = 0;
        int nm = 0;
        start_run();
        n_vec++;
        if (busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL run_busy: got %b expected 1", busy_o);
        end
        for (int i = 0; i < 100; i++) begin
            instr_i    = NOP;
            br_instr_i = (i % 10 == 0);
            br_miss_i  = (i % 10 == 0) && (i < 30);
            if (br_instr_i) nb++;
            if (br_instr_i && br_miss_i) nm++;
            step();
        end
        n_vec++;
        if ({win_valid_o, win_miss_o} !== 17'd0) begin
`ifdef BP_STAT_WINDOW_EN
            n_vec--;
`else
            n_err++;
            $display("FAIL run_win_tied: got %h expected 0", {win_valid_o, win_miss_o});
`endif
        end
        run_halt(n);
        n_vec++;
        if (n !== 7) begin
            n_err++;
            $display("FAIL run_halt_lat: got %0d expected 7", n);
        end
        exp_v = '{32'(100 + 7), 32'(nb), 32'(nm), 32'(ST_DONE)};
        for (int i = 0; i < 4; i++) begin
            rd_issue(2'(i), exp_v[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (rd_data_o !== e) begin
                n_err++;
                $display("FAIL run_sel%0d: got %h expected %h", i, rd_data_o, e);
            end
        end
    endtask

    task automatic test_halt_glitch();
        int n;
        logic [31:0] e;
        start_run();
        for (int i = 0; i < 8; i++) begin
            instr_i = (i == 3) ? NOP : HALT;
            step();
        end
        n_vec++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_busy: got %b%b expected 10", busy_o, done_o);
        end
        run_halt(n);
        n_vec++;
        if (n !== 3) begin
            n_err++;
            $display("FAIL glitch_drain: got %0d expected 3", n);
        end
        rd_issue(SEL_CYC, 32'd11);
        e = exp_q.pop_front();
        n_vec++;
        if (rd_data_o !== e) begin
            n_err++;
            $display("FAIL glitch_cyc: got %h expected %h", rd_data_o, e);
        end
    endtask

    task automatic test_miss_no_instr();
        int n;
        logic [31:0] e;
        logic [31:0] exp_v[4];
        start_run();
        for (int i = 0; i < 20; i++) begin
            br_instr_i = 1'b0;
            br_miss_i  = 1'b1;
            step();
        end
        run_halt(n);
        exp_v = '{32'd27, 32'd0, 32'd0, 32'(ST_DONE)};
        for (int i = 0; i < 4; i++) begin
            rd_issue(2'(i), exp_v[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (rd_data_o !== e) begin
                n_err++;
                $display("FAIL miss_sel%0d: got %h expected %h", i, rd_data_o, e);
            end
        end
    endtask

    task automatic test_saturate();
        int n;
        logic [31:0] e;
        logic [31:0] exp_v[4];
        start_run();
        force dut.u_br_cnt.cnt_q = 32'hFFFF_FFFE;
        step();
        release dut.u_br_cnt.cnt_q;
        br_instr_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        br_instr_i = 1'b0;
        run_halt(n);
        exp_v = '{32'd11, 32'hFFFF_FFFF, 32'd0,
                  32'(ST_DONE) | (32'd1 << STAT_BR_OVF)};
        for (int i = 0; i < 4; i++) begin
            rd_issue(2'(i), exp_v[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (rd_data_o !== e) begin
                n_err++;
                $display("FAIL sat_sel%0d: got %h expected %h", i, rd_data_o, e);
            end
        end
    endtask

    task automatic test_clear();
        logic [31:0] e;
        clear_i = 1'b1;
        start_i = 1'b1;
        step();
        clear_i = 1'b0;
        start_i = 1'b0;
        n_vec++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_err++;
            $display("FAIL clr_done_flags: got %b%b expected 00", busy_o, done_o);
        end
        for (int i = 0; i < 4; i++) begin
            rd_issue(2'(i), 32'd0);
            e = exp_q.pop_front();
            n_vec++;
            if (rd_data_o !== e) begin
                n_err++;
                $display("FAIL clr_done_sel%0d: got %h expected %h", i, rd_data_o, e);
            end
        end
        start_run();
        br_instr_i = 1'b1;
        for (int i = 0; i < 5; i++) step();
        clear_i = 1'b1;
        step();
        clear_i    = 1'b0;
        br_instr_i = 1'b0;
        n_vec++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL clr_run_busy: got %b expected 0", busy_o);
        end
        for (int i = 0; i < 4; i++) begin
            rd_issue(2'(i), 32'd0);
            e = exp_q.pop_front();
            n_vec++;
            if (rd_data_o !== e) begin
                n_err++;
                $display("FAIL clr_run_sel%0d: got %h expected %h", i, rd_data_o, e);
            end
        end
    endtask

`ifdef BP_STAT_WINDOW_EN
    task automatic test_window();
        int n;
        int early = 0;
        start_run();
        for (int i = 0; i < 16; i++) begin
            br_instr_i = (i < 5);
            br_miss_i  = (i < 5);
            if (win_valid_o) early++;
            step();
        end
        br_instr_i = 1'b0;
        br_miss_i  = 1'b0;
        n_vec++;
        if (early !== 0) begin
            n_err++;
            $display("FAIL win_early: got %0d pulses expected 0", early);
        end
        n_vec++;
        if (win_valid_o !== 1'b1 || win_miss_o !== 16'd5) begin
            n_err++;
            $display("FAIL win_pulse: got %b/%0d expected 1/5", win_valid_o, win_miss_o);
        end
        step();
        n_vec++;
        if (win_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL win_one_cycle: got %b expected 0", win_valid_o);
        end
        run_halt(n);
    endtask
`endif

    initial begin
        step();
        step();
        rst_ni = 1'b1;
        step();
        test_reset();
        test_run();
        test_halt_glitch();
        test_miss_no_instr();
        test_saturate();
        test_clear();
`ifdef BP_STAT_WINDOW_EN
        test_window();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
